// File: rtl/bf_pkg.sv
// Shared brainfuck definitions: opcode encoding, ASCII decoder and loader FSM state types.
package bf_pkg;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_LOOP  = 3'd4;
  localparam logic [2:0] OP_END   = 3'd5;
  localparam logic [2:0] OP_OUT   = 3'd6;
  localparam logic [2:0] OP_IN    = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
  } bfDecode_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {SESS_OFF, SESS_LOAD, SESS_FINISH} sessState_t;

  // Anything outside the eight command characters is a comment and decodes as not valid.
  function automatic bfDecode_t ascii_to_op(input logic [7:0] ch);
    bfDecode_t d;
    d.valid = 1'b1;
    d.op    = OP_INC;
    case (ch)
      8'h2B:   d.op = OP_INC;
      8'h2D:   d.op = OP_DEC;
      8'h3E:   d.op = OP_RIGHT;
      8'h3C:   d.op = OP_LEFT;
      8'h5B:   d.op = OP_LOOP;
      8'h5D:   d.op = OP_END;
      8'h2E:   d.op = OP_OUT;
      8'h2C:   d.op = OP_IN;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bf_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser; held idle while enable is low.
module bf_loader_uart_rx
  import bf_pkg::*;
#(
  parameter int CLK_PER_BIT = 10
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err_pulse,
  output logic       busy
);

  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_PER_BIT - 1);

  logic          rxMeta, rxSync, rxPrev;
  rxState_t      state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          validNext, ferrNext;

  always_ff @(posedge sysClk) begin
    if (reset) begin
      rxMeta          <= 1'b1;
      rxSync          <= 1'b1;
      rxPrev          <= 1'b1;
      state           <= RX_IDLE;
      cnt             <= '0;
      bitIdx          <= '0;
      valid           <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      rxMeta          <= rx;
      rxSync          <= rxMeta;
      rxPrev          <= rxSync;
      state           <= stateNext;
      cnt             <= cntNext;
      bitIdx          <= bitIdxNext;
      valid           <= validNext;
      frame_err_pulse <= ferrNext;
    end
  end

  always_ff @(posedge sysClk) begin
    shiftReg <= shiftNext;
  end

  // Sample points land mid-bit: half a bit after the start edge, then every full bit.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt + CW'(1);
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    validNext  = 1'b0;
    ferrNext   = 1'b0;
    case (state)
      RX_IDLE: begin
        cntNext = '0;
        if (rxPrev && !rxSync) stateNext = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_CNT) begin
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = rxSync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_CNT) begin
          cntNext    = '0;
          shiftNext  = {rxSync, shiftReg[7:1]};
          bitIdxNext = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_CNT) begin
          cntNext   = '0;
          stateNext = RX_IDLE;
          validNext = rxSync;
          ferrNext  = !rxSync;
        end
      end
      default: stateNext = RX_IDLE;
    endcase
    if (!enable) begin
      stateNext = RX_IDLE;
      cntNext   = '0;
      validNext = 1'b0;
      ferrNext  = 1'b0;
    end
  end

  assign data = shiftReg;
  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/bf_program_loader.sv
// UART program loader: filters and encodes brainfuck source into program memory with bracket checks.
// Optional LOADER_ECHO_EN retransmits each written instruction's ASCII byte on tx.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int CLK_PER_BIT = 10,
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  loading,
  input  logic                  rx,
  output logic                  tx,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [2:0]            wr_data,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  load_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overflow_err,
  output logic                  bracket_err
);

  localparam logic [ADDR_WIDTH:0]    MEM_SIZE  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

  sessState_t             sessState, sessNext;
  logic                   startSess, rxEnable;
  logic [7:0]             rxData;
  logic                   rxValid, rxFerr;
  logic [DEPTH_WIDTH-1:0] depth;
  bfDecode_t              dec;
  logic                   take, memFull, closeAtZero, wrGo;

  bf_loader_uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) uRx (
    .sysClk          (sysClk),
    .reset           (reset),
    .enable          (rxEnable),
    .rx              (rx),
    .data            (rxData),
    .valid           (rxValid),
    .frame_err_pulse (rxFerr),
    .busy            (busy)
  );

  always_comb begin
    sessNext  = sessState;
    startSess = 1'b0;
    case (sessState)
      SESS_OFF: begin
        if (loading) begin
          sessNext  = SESS_LOAD;
          startSess = 1'b1;
        end
      end
      SESS_LOAD:   if (!loading) sessNext = SESS_FINISH;
      SESS_FINISH: sessNext = SESS_OFF;
      default:     sessNext = SESS_OFF;
    endcase
  end

  // Dropping loading disables the receiver in the same cycle, so a partial frame never lands.
  assign rxEnable    = (sessState == SESS_LOAD) && loading;
  assign dec         = ascii_to_op(rxData);
  assign take        = rxValid && rxEnable && dec.valid;
  assign memFull     = (prog_len == MEM_SIZE);
  assign closeAtZero = (dec.op == OP_END) && (depth == '0);
  assign wrGo        = take && !memFull && !closeAtZero;

  always_ff @(posedge sysClk) begin
    if (reset) begin
      sessState    <= SESS_OFF;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      prog_len     <= '0;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
      bracket_err  <= 1'b0;
      depth        <= '0;
    end else begin
      sessState <= sessNext;
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      if (startSess) begin
        prog_len     <= '0;
        wr_addr      <= '0;
        depth        <= '0;
        frame_err    <= 1'b0;
        overflow_err <= 1'b0;
        bracket_err  <= 1'b0;
      end
      if (take && memFull) overflow_err <= 1'b1;
      if (take && !memFull && closeAtZero) bracket_err <= 1'b1;
      if (wrGo) begin
        wr_en    <= 1'b1;
        wr_addr  <= prog_len[ADDR_WIDTH-1:0];
        wr_data  <= dec.op;
        prog_len <= prog_len + (ADDR_WIDTH+1)'(1);
        // A '[' beyond max nesting is still stored but flagged; depth saturates.
        if (dec.op == OP_LOOP) begin
          if (depth == DEPTH_MAX) bracket_err <= 1'b1;
          else depth <= depth + DEPTH_WIDTH'(1);
        end else if (dec.op == OP_END) begin
          depth <= depth - DEPTH_WIDTH'(1);
        end
      end
      if (rxFerr && rxEnable) frame_err <= 1'b1;
      if (sessState == SESS_FINISH) begin
        load_done <= 1'b1;
        if (depth != '0) bracket_err <= 1'b1;
      end
    end
  end

`ifdef LOADER_ECHO_EN
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_PER_BIT - 1);

  logic [7:0]    echoByte, holdByte;
  logic [9:0]    txShift;
  logic [CW-1:0] txCnt;
  logic [3:0]    txBit;
  logic          txBusy, holdFull, frameFree;

  assign frameFree = !txBusy || ((txCnt == FULL_CNT) && (txBit == 4'd9));

  always_ff @(posedge sysClk) begin
    if (reset) begin
      txBusy   <= 1'b0;
      holdFull <= 1'b0;
      txCnt    <= '0;
      txBit    <= '0;
    end else if (frameFree) begin
      txCnt <= '0;
      txBit <= '0;
      if (holdFull) begin
        txBusy   <= 1'b1;
        holdFull <= wr_en;
      end else begin
        txBusy <= wr_en;
      end
    end else begin
      if (txCnt == FULL_CNT) begin
        txCnt <= '0;
        txBit <= txBit + 4'd1;
      end else begin
        txCnt <= txCnt + CW'(1);
      end
      if (wr_en) holdFull <= 1'b1;
    end
  end

  // Holding register takes a new byte only when it is free after this edge's launch decision.
  always_ff @(posedge sysClk) begin
    if (wrGo) echoByte <= rxData;
    if (frameFree && holdFull) txShift <= {1'b1, holdByte, 1'b0};
    else if (frameFree && wr_en) txShift <= {1'b1, echoByte, 1'b0};
    else if (!frameFree && txCnt == FULL_CNT) txShift <= {1'b1, txShift[9:1]};
    if (wr_en && (frameFree ? holdFull : !holdFull)) holdByte <= echoByte;
  end

  assign tx = txBusy ? txShift[0] : 1'b1;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_bf_program_loader.sv
// Scoreboard bench for bf_program_loader: stimulus queues expected writes, monitors pop and compare.
module tb_bf_program_loader;

  localparam int AW  = 4;
  localparam int CPB = 10;
  localparam int DW  = 4;

  logic          clk = 1'b0;
  logic          reset, loading, rx;
  logic          tx, wr_en, load_done, busy, frame_err, overflow_err, bracket_err;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic [AW:0]   prog_len;

  int nTests = 0;
  int nFail  = 0;
  int expQ[$];
`ifdef LOADER_ECHO_EN
  logic [7:0] echoQ[$];
`endif

  always #5 clk = ~clk;

  bf_program_loader #(.ADDR_WIDTH(AW), .CLK_PER_BIT(CPB), .DEPTH_WIDTH(DW)) dut (
    .sysClk       (clk),
    .reset        (reset),
    .loading      (loading),
    .rx           (rx),
    .tx           (tx),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .prog_len     (prog_len),
    .load_done    (load_done),
    .busy         (busy),
    .frame_err    (frame_err),
    .overflow_err (overflow_err),
    .bracket_err  (bracket_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushW(input int addr, input int op, input logic [7:0] ch);
    expQ.push_back((addr << 3) | op);
`ifdef LOADER_ECHO_EN
    echoQ.push_back(ch);
`endif
  endtask

  // Write monitor: every strobe must match the oldest expected (addr, opcode).
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpectedWrite: got addr %0d op %0d, expected no write", wr_addr, wr_data);
      end else begin
        int e;
        e = expQ.pop_front();
        if ({wr_addr, wr_data} != e[AW+2:0]) begin
          nFail++;
          $display("FAIL write: got addr %0d op %0d, expected addr %0d op %0d",
                   wr_addr, wr_data, e >> 3, e & 7);
        end
      end
    end
  end

`ifdef LOADER_ECHO_EN
  initial begin : echoMon
    logic [7:0] b;
    logic       stopBit;
    forever begin
      @(negedge clk);
      if (!reset && !tx) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopBit = tx;
        nTests++;
        if (echoQ.size() == 0) begin
          nFail++;
          $display("FAIL unexpectedEcho: got 0x%02h, expected none", b);
        end else begin
          logic [7:0] e;
          e = echoQ.pop_front();
          if (b != e || !stopBit) begin
            nFail++;
            $display("FAIL echo: got 0x%02h stop %0d, expected 0x%02h stop 1", b, stopBit, e);
          end
        end
      end
    end
  end
`endif

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b1);
  endtask

  task automatic startSession();
    loading = 1'b1;
    repeat (2) @(negedge clk);
    check("startLen", prog_len, 0);
    check("startErrs", {frame_err, overflow_err, bracket_err}, 0);
  endtask

  task automatic endSession();
    loading = 1'b0;
    @(negedge clk); check("loadDoneEarly", load_done, 0);
    @(negedge clk); check("loadDone", load_done, 1);
    @(negedge clk); check("loadDonePulse", load_done, 0);
  endtask

  task automatic checkTxIdle();
`ifndef LOADER_ECHO_EN
    check("txIdle", tx, 1);
`endif
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "Tx"}, tx, 1);
    check({tag, "WrEn"}, wr_en, 0);
    check({tag, "WrAddr"}, wr_addr, 0);
    check({tag, "WrData"}, wr_data, 0);
    check({tag, "ProgLen"}, prog_len, 0);
    check({tag, "Flags"}, {load_done, busy, frame_err, overflow_err, bracket_err}, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; loading = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("rstHeld");
    reset = 1'b0;
    @(negedge clk);
    checkResetState("rstRel");

    // Balanced loop program
    startSession();
    pushW(0, 0, "+"); pushW(1, 4, "["); pushW(2, 6, "."); pushW(3, 0, "+"); pushW(4, 5, "]");
    sendStr("+[.+]");
    endSession();
    check("loopLen", prog_len, 5);
    check("loopErrs", {frame_err, overflow_err, bracket_err}, 0);
    check("loopQ", expQ.size(), 0);
    checkTxIdle();
    repeat (20) @(negedge clk);
    check("lenHoldsOff", prog_len, 5);

    // Comments are dropped
    startSession();
    pushW(0, 0, "+"); pushW(1, 1, "-");
    sendStr("a+ \n-");
    endSession();
    check("commentLen", prog_len, 2);
    check("commentQ", expQ.size(), 0);

    // Overflow: 17th instruction refused
    startSession();
    for (int i = 0; i < 16; i++) pushW(i, 0, "+");
    for (int i = 0; i < 17; i++) sendByte("+", 1'b1);
    check("ovfErr", overflow_err, 1);
    check("ovfLen", prog_len, 16);
    endSession();
    check("ovfQ", expQ.size(), 0);
    check("ovfBracket", bracket_err, 0);

    // Unmatched close
    startSession();
    sendStr("]");
    check("closeErr", bracket_err, 1);
    check("closeLen", prog_len, 0);
    endSession();

    // Unclosed opens flagged at end
    startSession();
    pushW(0, 4, "["); pushW(1, 4, "[");
    sendStr("[[");
    check("openErrBefore", bracket_err, 0);
    endSession();
    check("openErrAfter", bracket_err, 1);
    check("openLen", prog_len, 2);

    // Stop bit low
    startSession();
    sendByte("+", 1'b0);
    check("frameErr", frame_err, 1);
    check("frameLen", prog_len, 0);
    endSession();

    // Short glitch is rejected
    startSession();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitchBusy", busy, 1);
    repeat (3 * CPB) @(negedge clk);
    check("glitchIdle", busy, 0);
    check("glitchLen", prog_len, 0);
    check("glitchFrameErr", frame_err, 0);
    endSession();

    // Loading dropped mid-frame
    startSession();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h2B >> i);
      repeat (CPB) @(negedge clk);
    end
    check("midBusy", busy, 1);
    endSession();
    check("midAbandon", busy, 0);
    rx = 1'b1;
    repeat (15 * CPB) @(negedge clk);
    check("midLen", prog_len, 0);
    check("midQ", expQ.size(), 0);

    // Echo stream: "+x-"
    startSession();
    pushW(0, 0, "+"); pushW(1, 1, "-");
    sendStr("+x-");
    endSession();
    check("echoLen", prog_len, 2);
    repeat (12 * CPB) @(negedge clk);

    // Reset mid-frame after state has accumulated
    startSession();
    sendStr("]");
    pushW(0, 1, "-");
    sendStr("-");
    check("preRstLen", prog_len, 1);
    check("preRstBracket", bracket_err, 1);
`ifdef LOADER_ECHO_EN
    repeat (12 * CPB) @(negedge clk);
`endif
    rx = 1'b0;
    repeat (CPB + 3) @(negedge clk);
    check("preRstBusy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("rstMid");
    rx = 1'b1; loading = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("rstAfter");

    repeat (12 * CPB) @(negedge clk);
    check("finalQ", expQ.size(), 0);
`ifdef LOADER_ECHO_EN
    check("finalEchoQ", echoQ.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
